// File: rtl/legv8_pkg.sv
// LEGv8 instruction-encoder shared definitions: symbolic op codes and the
// opcode field values shared with the control decoder.
package legv8_pkg;

    // Symbolic request op codes; codes 14 and 15 are unused and treated as illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_EOR  = 4'd4,
        OP_LDUR = 4'd5,
        OP_STUR = 4'd6,
        OP_LSL  = 4'd7,
        OP_LSR  = 4'd8,
        OP_BR   = 4'd9,
        OP_CBZ  = 4'd10,
        OP_CBNZ = 4'd11,
        OP_B    = 4'd12,
        OP_BL   = 4'd13
    } op_t;

    // R- and D-format 11-bit opcodes
    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_EOR  = 11'h650;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [10:0] OPC_LSL  = 11'h69B;
    localparam logic [10:0] OPC_LSR  = 11'h69A;
    localparam logic [10:0] OPC_BR   = 11'h6B0;

    // CB-format 8-bit opcodes
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;
    localparam logic [7:0]  OPC_CBNZ = 8'hB5;

    // B-format 6-bit opcodes
    localparam logic [5:0]  OPC_B    = 6'h05;
    localparam logic [5:0]  OPC_BL   = 6'h25;

    // True when the upper bits of a 26-bit value from bit TOP are all sign copies,
    // i.e. the value fits a signed field of width TOP+1.
    function automatic logic sign_bits_equal(input logic [25:0] v, input logic [25:0] mask);
        return ((v & mask) == mask) || ((v & mask) == 26'd0);
    endfunction

endpackage

// File: rtl/legv8_instr_encoder_if.sv
// Request/imem-write bundle of the LEGv8 instruction encoder.
// master: the loader/memory side; slave: the encoder.
interface legv8_instr_encoder_if #(
    parameter int ADDR_W = 12
);
    import legv8_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [25:0]       in_imm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              clr_err;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] word_count;
    logic              err_illegal;
    logic              err_range;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
               base_load, base_addr, clr_err, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               word_count, err_illegal, err_range
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
               base_load, base_addr, clr_err, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata,
               word_count, err_illegal, err_range
    );

endinterface

// File: rtl/legv8_enc_word.sv
// Combinational LEGv8 encoder: symbolic op + fields -> 32-bit word plus
// illegal-op and immediate-range flags.
// Optional feature macro: LEGV8_ENC_RANGE_CHECK_EN (immediate range checking).
module legv8_enc_word
    import legv8_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rn,
    input  logic [4:0]  i_rm,
    input  logic [25:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal,
    output logic        o_range_err
);

    // Assemble the instruction word for the requested format
    always_comb begin
        o_word    = 32'd0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:  o_word = {OPC_ADD,  i_rm, 6'd0, i_rn, i_rd};
            OP_SUB:  o_word = {OPC_SUB,  i_rm, 6'd0, i_rn, i_rd};
            OP_AND:  o_word = {OPC_AND,  i_rm, 6'd0, i_rn, i_rd};
            OP_ORR:  o_word = {OPC_ORR,  i_rm, 6'd0, i_rn, i_rd};
            OP_EOR:  o_word = {OPC_EOR,  i_rm, 6'd0, i_rn, i_rd};
            OP_LDUR: o_word = {OPC_LDUR, i_imm[8:0], 2'b00, i_rn, i_rd};
            OP_STUR: o_word = {OPC_STUR, i_imm[8:0], 2'b00, i_rn, i_rd};
            OP_LSL:  o_word = {OPC_LSL,  5'd0, i_imm[5:0], i_rn, i_rd};
            OP_LSR:  o_word = {OPC_LSR,  5'd0, i_imm[5:0], i_rn, i_rd};
            OP_BR:   o_word = {OPC_BR,   5'd0, 6'd0, i_rn, 5'd0};
            OP_CBZ:  o_word = {OPC_CBZ,  i_imm[18:0], i_rd};
            OP_CBNZ: o_word = {OPC_CBNZ, i_imm[18:0], i_rd};
            OP_B:    o_word = {OPC_B,    i_imm};
            OP_BL:   o_word = {OPC_BL,   i_imm};
            default: o_illegal = 1'b1;
        endcase
    end

`ifdef LEGV8_ENC_RANGE_CHECK_EN
    // Flag immediates that do not fit their field; illegal ops never raise it
    always_comb begin
        o_range_err = 1'b0;
        case (i_op)
            OP_LDUR, OP_STUR: o_range_err = ~sign_bits_equal(i_imm, 26'h3FFFF00);
            OP_CBZ,  OP_CBNZ: o_range_err = ~sign_bits_equal(i_imm, 26'h3FC0000);
            OP_LSL,  OP_LSR:  o_range_err = |i_imm[25:6];
            default:          o_range_err = 1'b0;
        endcase
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder top: accepts symbolic requests, encodes them and
// writes them sequentially into imem through a one-entry output register.
// Optional feature macro: LEGV8_ENC_RANGE_CHECK_EN (drops out-of-range immediates
// and reports them on err_range; otherwise immediates are truncated).
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int ADDR_INC = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    legv8_instr_encoder_if.slave  bus
);

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_count;
    logic              r_err_illegal;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_load;
    logic              w_done;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_range_err;

    legv8_enc_word u_enc (
        .i_op        (bus.in_op),
        .i_rd        (bus.in_rd),
        .i_rn        (bus.in_rn),
        .i_rm        (bus.in_rm),
        .i_imm       (bus.in_imm),
        .o_word      (w_word),
        .o_illegal   (w_illegal),
        .o_range_err (w_range_err)
    );

    // The output register can take a new word whenever it is empty or draining
    assign w_in_ready = ~r_we | bus.imem_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    // Illegal or out-of-range requests are consumed but never written
    assign w_load     = w_accept & ~w_illegal & ~w_range_err;
    assign w_done     = r_we & bus.imem_ready;
    // A same-cycle base_load redirects the word being accepted
    assign w_wr_addr  = bus.base_load ? bus.base_addr : r_next_addr;

    // Output register: load on a legal accept, empty once the memory takes the word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (w_load) begin
            r_we    <= 1'b1;
            r_addr  <= w_wr_addr;
            r_wdata <= w_word;
        end else if (bus.imem_ready) begin
            r_we    <= 1'b0;
        end
    end

    // Next write address: advances per legal accept, wraps naturally modulo 2**ADDR_W
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_next_addr <= '0;
        end else if (w_load) begin
            r_next_addr <= w_wr_addr + ADDR_W'(ADDR_INC);
        end else if (bus.base_load) begin
            r_next_addr <= bus.base_addr;
        end
    end

    // Completed-write counter, restarted by base_load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (bus.base_load) begin
            r_count <= '0;
        end else if (w_done) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    // Sticky illegal-op flag; a new error beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_illegal <= 1'b0;
        end else begin
            r_err_illegal <= (r_err_illegal & ~bus.clr_err) | (w_accept & w_illegal);
        end
    end

`ifdef LEGV8_ENC_RANGE_CHECK_EN
    logic r_err_range;

    // Sticky range flag; a new error beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_range <= 1'b0;
        end else begin
            r_err_range <= (r_err_range & ~bus.clr_err) | (w_accept & w_range_err);
        end
    end

    assign bus.err_range = r_err_range;
`else
    assign bus.err_range = 1'b0;
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.imem_we     = r_we;
    assign bus.imem_addr   = r_addr;
    assign bus.imem_wdata  = r_wdata;
    assign bus.word_count  = r_count;
    assign bus.err_illegal = r_err_illegal;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder: known-answer vector table,
// directed stall/illegal/range/wrap/reset sequences, then randomized traffic
// against a transaction-level reference model.
// Honors LEGV8_ENC_RANGE_CHECK_EN for the out-of-range immediate case.
module tb_legv8_instr_encoder;

    localparam int AW = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    legv8_instr_encoder_if #(.ADDR_W(AW)) bus();

    legv8_instr_encoder #(.ADDR_W(AW), .ADDR_INC(4)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          op;
        int          rd;
        int          rn;
        int          rm;
        int          imm;
        logic [31:0] want;
    } vec_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] word;
    } wr_t;

    vec_t vt[10];
    wr_t  exp_q[$];

    // Independent opcode table indexed by op code 0..13
    int opc_tab[14] = '{'h458, 'h658, 'h450, 'h550, 'h650, 'h7C2, 'h7C0,
                        'h69B, 'h69A, 'h6B0, 'hB4, 'hB5, 'h05, 'h25};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int rd, input int rn, input int rm, input int imm);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'(op);
        bus.in_rd    = 5'(rd);
        bus.in_rn    = 5'(rn);
        bus.in_rm    = 5'(rm);
        bus.in_imm   = 26'(imm);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    function automatic longint pmod(input longint a, input longint m);
        return ((a % m) + m) % m;
    endfunction

    // Reference encoding straight from the field layout, using plain arithmetic
    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rn,
                                               input int rm, input int imm);
        longint opc;
        longint w;
        opc = longint'(opc_tab[op]);
        w   = 0;
        case (op)
            0, 1, 2, 3, 4: w = opc * 2097152 + rm * 65536 + rn * 32 + rd;
            5, 6:          w = opc * 2097152 + pmod(imm, 512) * 4096 + rn * 32 + rd;
            7, 8:          w = opc * 2097152 + pmod(imm, 64) * 1024 + rn * 32 + rd;
            9:             w = opc * 2097152 + rn * 32;
            10, 11:        w = opc * 16777216 + pmod(imm, 524288) * 32 + rd;
            12, 13:        w = opc * 67108864 + pmod(imm, 67108864);
            default:       w = 0;
        endcase
        return 32'(w);
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.base_load  = 1'b0;
        bus.clr_err    = 1'b0;
        bus.imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_addr;

        vt[0] = '{0,  1,  2,  3,  0, 32'h8B030041};   // ADD
        vt[1] = '{5,  9, 10,  0,  8, 32'hF8408149};   // LDUR
        vt[2] = '{10, 5,  0,  0, -2, 32'hB4FFFFC5};   // CBZ
        vt[3] = '{12, 0,  0,  0,  1, 32'h14000001};   // B
        vt[4] = '{13, 0,  0,  0,  0, 32'h94000000};   // BL
        vt[5] = '{1,  4,  5,  6,  0, 32'hCB0600A4};   // SUB
        vt[6] = '{7,  1,  2,  7,  3, 32'hD3600C41};   // LSL: Rm forced 0
        vt[7] = '{9,  3, 30,  4,  0, 32'hD60003C0};   // BR: Rm, Rd forced 0
        vt[8] = '{6,  2, 31,  0, -1, 32'hF81FF3E2};   // STUR
        vt[9] = '{11, 7,  0,  0,  4, 32'hB5000087};   // CBNZ

        bus.in_valid   = 1'b0;
        bus.in_op      = 4'd0;
        bus.in_rd      = 5'd0;
        bus.in_rn      = 5'd0;
        bus.in_rm      = 5'd0;
        bus.in_imm     = 26'd0;
        bus.base_load  = 1'b0;
        bus.base_addr  = 12'd0;
        bus.clr_err    = 1'b0;
        bus.imem_ready = 1'b1;

        // Reset state, sampled while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",       32'(bus.imem_we),     32'd0);
        check("rst_addr",     32'(bus.imem_addr),   32'd0);
        check("rst_wdata",    bus.imem_wdata,       32'd0);
        check("rst_count",    32'(bus.word_count),  32'd0);
        check("rst_err_ill",  32'(bus.err_illegal), 32'd0);
        check("rst_err_rng",  32'(bus.err_range),   32'd0);
        check("rst_in_ready", 32'(bus.in_ready),    32'd1);
        rst_n = 1'b1;

        // Known-answer table, memory always ready
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].op, vt[i].rd, vt[i].rn, vt[i].rm, vt[i].imm);
            tick();
            $display("tx vec%0d op=%0d addr=0x%03h wdata=0x%08h", i, vt[i].op, bus.imem_addr, bus.imem_wdata);
            check($sformatf("vec%0d_we", i),   32'(bus.imem_we),   32'd1);
            check($sformatf("vec%0d_addr", i), 32'(bus.imem_addr), 32'(i * 4));
            check($sformatf("vec%0d_data", i), bus.imem_wdata,     vt[i].want);
            idle();
            tick();
            check($sformatf("vec%0d_count", i), 32'(bus.word_count), 32'(i + 1));
            check($sformatf("vec%0d_drain", i), 32'(bus.imem_we),    32'd0);
        end

        // Three-cycle stall with a word pending and a second request waiting
        bus.imem_ready = 1'b0;
        drive(0, 1, 2, 3, 0);
        tick();
        check("stall_we",   32'(bus.imem_we),   32'd1);
        check("stall_addr", 32'(bus.imem_addr), 32'd40);
        drive(3, 1, 2, 3, 0);
        #1;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d_in_ready", k), 32'(bus.in_ready),  32'd0);
            check($sformatf("stall%0d_addr", k),     32'(bus.imem_addr), 32'd40);
            check($sformatf("stall%0d_wdata", k),    bus.imem_wdata,     32'h8B030041);
        end
        bus.imem_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        $display("tx stall-release addr=0x%03h wdata=0x%08h", bus.imem_addr, bus.imem_wdata);
        check("unstall_addr",  32'(bus.imem_addr),  32'd44);
        check("unstall_wdata", bus.imem_wdata,      32'hAA030041);
        check("unstall_count", 32'(bus.word_count), 32'd11);
        idle();
        tick();
        check("unstall_count2", 32'(bus.word_count), 32'd12);

        // Illegal op: consumed, no write, address held
        drive(15, 1, 2, 3, 0);
        tick();
        $display("tx illegal op=15");
        check("ill_we",     32'(bus.imem_we),     32'd0);
        check("ill_err",    32'(bus.err_illegal), 32'd1);
        check("ill_ready",  32'(bus.in_ready),    32'd1);
        drive(0, 1, 2, 3, 0);
        tick();
        check("ill_next_addr", 32'(bus.imem_addr), 32'd48);
        check("ill_next_data", bus.imem_wdata,     32'h8B030041);
        idle();
        bus.clr_err = 1'b1;
        tick();
        check("ill_clr", 32'(bus.err_illegal), 32'd0);
        drive(14, 0, 0, 0, 0);
        tick();
        check("ill_set_beats_clr", 32'(bus.err_illegal), 32'd1);
        idle();
        tick();
        check("ill_clr2", 32'(bus.err_illegal), 32'd0);
        bus.clr_err = 1'b0;
        exp_addr = 52;

        // LDUR with an immediate one past the signed 9-bit range
        drive(5, 9, 10, 0, 256);
        tick();
        $display("tx ldur imm=256 we=%0d wdata=0x%08h", bus.imem_we, bus.imem_wdata);
`ifdef LEGV8_ENC_RANGE_CHECK_EN
        check("rng_we",  32'(bus.imem_we),   32'd0);
        check("rng_err", 32'(bus.err_range), 32'd1);
        idle();
        bus.clr_err = 1'b1;
        tick();
        check("rng_clr", 32'(bus.err_range), 32'd0);
        bus.clr_err = 1'b0;
`else
        check("trunc_we",   32'(bus.imem_we),   32'd1);
        check("trunc_addr", 32'(bus.imem_addr), 32'(exp_addr));
        check("trunc_data", bus.imem_wdata,     32'hF8500149);
        check("trunc_err",  32'(bus.err_range), 32'd0);
        idle();
        tick();
`endif

        // base_load near the top of the address space, then wrap
        bus.base_addr = 12'hFFC;
        bus.base_load = 1'b1;
        tick();
        bus.base_load = 1'b0;
        check("base_count_clr", 32'(bus.word_count), 32'd0);
        drive(0, 1, 2, 3, 0);
        tick();
        check("wrap_addr0", 32'(bus.imem_addr), 32'hFFC);
        drive(0, 2, 2, 3, 0);
        tick();
        check("wrap_addr1", 32'(bus.imem_addr), 32'h000);
        idle();
        tick();
        check("wrap_count", 32'(bus.word_count), 32'd2);

        // base_load in the same cycle as an accept
        bus.base_addr = 12'h100;
        bus.base_load = 1'b1;
        drive(0, 1, 2, 3, 0);
        tick();
        bus.base_load = 1'b0;
        check("same_cyc_addr0", 32'(bus.imem_addr), 32'h100);
        tick();
        check("same_cyc_addr1", 32'(bus.imem_addr), 32'h104);
        idle();
        tick();

        // Asynchronous reset during a stall discards the pending word at once
        bus.imem_ready = 1'b0;
        drive(0, 1, 2, 3, 0);
        tick();
        check("rststall_we_before", 32'(bus.imem_we), 32'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rststall_we",    32'(bus.imem_we),    32'd0);
        check("rststall_count", 32'(bus.word_count), 32'd0);
        check("rststall_addr",  32'(bus.imem_addr),  32'd0);
        #2;
        rst_n = 1'b1;
        bus.imem_ready = 1'b1;
        tick();
        check("rststall_after", 32'(bus.imem_we), 32'd0);

        // Randomized traffic against the transaction-level model
        do_reset();
        begin
            int  m_next_addr;
            int  m_count;
            bit  m_err;
            m_next_addr = 0;
            m_count     = 0;
            m_err       = 1'b0;
            exp_q.delete();
            for (int c = 0; c < 400; c++) begin
                int   op;
                int   rd;
                int   rn;
                int   rm;
                int   imm;
                logic v;
                logic rdy;
                logic exp_rdy;
                logic [31:0] w;
                v   = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 3) != 0);
                op  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 15))
                                                    : int'($urandom_range(0, 13));
                rd  = int'($urandom_range(0, 31));
                rn  = int'($urandom_range(0, 31));
                rm  = int'($urandom_range(0, 31));
                case (op)
                    5, 6:    imm = int'($urandom_range(0, 511)) - 256;
                    7, 8:    imm = int'($urandom_range(0, 63));
                    10, 11:  imm = int'($urandom_range(0, 524287)) - 262144;
                    12, 13:  imm = int'($urandom_range(0, 67108863)) - 33554432;
                    default: imm = int'($urandom_range(0, 67108863));
                endcase
                if (v) drive(op, rd, rn, rm, imm);
                else   idle();
                bus.imem_ready = rdy;
                #1;
                exp_rdy = (exp_q.size() == 0) || rdy;
                check("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
                check("rnd_we",       32'(bus.imem_we),  32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("rnd_addr",  32'(bus.imem_addr), 32'(exp_q[0].addr));
                    check("rnd_wdata", bus.imem_wdata,     exp_q[0].word);
                end
                check("rnd_count",   32'(bus.word_count),  32'(m_count));
                check("rnd_err_ill", 32'(bus.err_illegal), 32'(m_err));
                check("rnd_err_rng", 32'(bus.err_range),   32'd0);
                if (exp_q.size() != 0 && rdy) begin
                    void'(exp_q.pop_front());
                    m_count = (m_count + 1) % 4096;
                end
                if (v && exp_rdy) begin
                    if (op <= 13) begin
                        w = ref_encode(op, rd, rn, rm, imm);
                        exp_q.push_back('{addr: 12'(m_next_addr), word: w});
                        $display("tx rnd%0d op=%0d addr=0x%03h word=0x%08h", c, op, m_next_addr, w);
                        m_next_addr = (m_next_addr + 4) % 4096;
                    end else begin
                        m_err = 1'b1;
                        $display("tx rnd%0d op=%0d dropped", c, op);
                    end
                end
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
